// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: pc-source encodings and controller states shared by the fetch controller
package fetch_ctrl_pkg;
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;
  typedef enum logic [1:0] {HOLD, RUN, MEM_WAIT, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: pipeline request inputs and fetch-datapath control outputs
interface fetch_ctrl_if #(parameter int STALL_CNT_W = 16);
  logic branch_taken, jump_req, load_use_hazard, halt_req, imem_ready;
  logic imem_req;
  logic [1:0] pc_src;
  logic pc_write, ifid_write, ifid_flush, idex_flush, halted, fetch_error;
  logic [STALL_CNT_W-1:0] stall_count;
  modport master (
    input  branch_taken, jump_req, load_use_hazard, halt_req, imem_ready,
    output imem_req, pc_src, pc_write, ifid_write, ifid_flush, idex_flush, halted, fetch_error, stall_count
  );
  modport slave (
    output branch_taken, jump_req, load_use_hazard, halt_req, imem_ready,
    input  imem_req, pc_src, pc_write, ifid_write, ifid_flush, idex_flush, halted, fetch_error, stall_count
  );
endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter: up-counter with sync clear that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk)
    o_q <= i_clr ? '0 : (i_en && !(&o_q)) ? o_q + 1'b1 : o_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: picks next-PC source and PC / IF/ID load, flush or hold each cycle
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int MEM_TIMEOUT       = 16,
  parameter int STALL_CNT_W       = 16
) (
  input logic        clk,
  input logic        rst,
  fetch_ctrl_if.master bus
);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  fetch_state_t r_state, w_next;
  logic [HW-1:0] r_hold_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic r_fetch_error, w_active, w_timeout;
  assign w_active = !rst && (r_state == RUN || r_state == MEM_WAIT);
  assign bus.fetch_error = r_fetch_error;
  always_comb begin
    w_next = r_state;
    w_timeout = 1'b0;
    bus.imem_req = w_active;
    bus.pc_src = PCSRC_SEQ;
    bus.pc_write = 1'b0;
    bus.ifid_write = 1'b0;
    bus.ifid_flush = !w_active;
    bus.idex_flush = 1'b0;
    bus.halted = !rst && r_state == HALTED;
    if (rst || r_state == HOLD) begin
      bus.idex_flush = 1'b1;
      w_next = (r_hold_cnt == HW'(RESET_HOLD_CYCLES - 1)) ? RUN : HOLD;
    end else if (w_active) begin
      if (bus.branch_taken) begin
        bus.pc_src = PCSRC_BRANCH;
        bus.pc_write = 1'b1;
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
        w_next = RUN;
      end else if (bus.load_use_hazard) begin
        bus.idex_flush = 1'b1;
      end else if (bus.halt_req) begin
        bus.ifid_flush = 1'b1;
        w_next = HALTED;
      end else if (bus.jump_req) begin
        bus.pc_src = PCSRC_JUMP;
        bus.pc_write = 1'b1;
        bus.ifid_flush = 1'b1;
        w_next = RUN;
      end else if (!bus.imem_ready) begin
        bus.ifid_flush = 1'b1;
        w_timeout = r_wait_cnt == WW'(MEM_TIMEOUT);
        w_next = w_timeout ? HALTED : MEM_WAIT;
      end else begin
        bus.pc_write = 1'b1;
        bus.ifid_write = 1'b1;
        w_next = RUN;
      end
    end
  end
  // wait counter parks at MEM_TIMEOUT so a hazard stall inside a wait cannot skip the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HOLD;
      r_hold_cnt <= '0;
      r_wait_cnt <= '0;
      r_fetch_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold_cnt <= (r_state == HOLD) ? r_hold_cnt + 1'b1 : r_hold_cnt;
      r_wait_cnt <= (w_next == MEM_WAIT) ? r_wait_cnt + WW'(r_wait_cnt != WW'(MEM_TIMEOUT)) : '0;
      r_fetch_error <= r_fetch_error | w_timeout;
    end
  end
  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk  (clk),
    .i_clr(rst),
    .i_en (w_active && !bus.pc_write),
    .o_q  (bus.stall_count)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed test-plan sequences plus random traffic against a rule-table model
module tb_fetch_ctrl;
  localparam int H = 2, T = 4, W = 3;
  localparam int SMAX = (1 << W) - 1;
  // rule outputs {pc_src, pc_write, ifid_write, ifid_flush, idex_flush, halted} in priority order
  localparam logic [6:0] RT [0:5] = '{7'b1010110, 7'b0000010, 7'b0000100, 7'b0110100, 7'b0000100, 7'b0011000};
  localparam logic [7:0] V_HOLD = 8'b00000110, V_HALT = 8'b00000101;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  fetch_ctrl_if #(.STALL_CNT_W(W)) bus();
  fetch_ctrl #(.RESET_HOLD_CYCLES(H), .MEM_TIMEOUT(T), .STALL_CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0, n_pass = 0;
  int m_mode = 0, m_hold = 0, m_waits = 0, m_stalls = 0;
  bit m_err = 1'b0;
  function automatic int rule_of();
    if (bus.branch_taken) return 0;
    if (bus.load_use_hazard) return 1;
    if (bus.halt_req) return 2;
    if (bus.jump_req) return 3;
    if (!bus.imem_ready) return 4;
    return 5;
  endfunction
  function automatic logic [7:0] exp_vec();
    if (rst || m_mode == 0) return V_HOLD;
    if (m_mode == 3) return V_HALT;
    return {1'b1, RT[rule_of()]};
  endfunction
  function automatic logic [7:0] dut_vec();
    return {bus.imem_req, bus.pc_src, bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.halted};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic model_step();
    int r, nm;
    if (rst) begin
      m_mode = 0; m_hold = 0; m_waits = 0; m_stalls = 0; m_err = 1'b0;
    end else if (m_mode == 0) begin
      m_hold++;
      if (m_hold == H) m_mode = 1;
    end else if (m_mode != 3) begin
      r = rule_of();
      if (!RT[r][4]) m_stalls = (m_stalls < SMAX) ? m_stalls + 1 : SMAX;
      nm = (r == 0 || r == 3 || r == 5) ? 1 : (r == 1) ? m_mode : (r == 2) ? 3 :
           (m_mode == 2 && m_waits >= T) ? 3 : 2;
      if (r == 4 && nm == 3) m_err = 1'b1;
      m_waits = (nm == 2) ? ((m_waits < T) ? m_waits + 1 : T) : 0;
      m_mode = nm;
    end
  endtask
  task automatic drive(input logic r, input logic bt, input logic lu, input logic hl, input logic jr, input logic rdy);
    rst = r;
    bus.branch_taken = bt;
    bus.load_use_hazard = lu;
    bus.halt_req = hl;
    bus.jump_req = jr;
    bus.imem_ready = rdy;
    @(negedge clk);
    chk("ctrl", 32'(dut_vec()), 32'(exp_vec()));
    chk("stall_count", 32'(bus.stall_count), 32'(m_stalls));
    chk("fetch_error", 32'(bus.fetch_error), 32'(m_err));
    chk("inv_ifid", 32'(bus.ifid_write & bus.ifid_flush), 32'd0);
    chk("inv_pcw_req", 32'(bus.pc_write & ~bus.imem_req), 32'd0);
  endtask
  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.branch_taken = 1'b0; bus.load_use_hazard = 1'b0; bus.halt_req = 1'b0;
    bus.jump_req = 1'b0; bus.imem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1); chk("rst_vec", 32'(dut_vec()), 32'(V_HOLD)); adv();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk("hold_req", 32'(bus.imem_req), 32'd0); chk("hold_iff", 32'(bus.ifid_flush), 32'd1); adv();
    end
    drive(0, 0, 0, 0, 0, 1);
    chk("run_req", 32'(bus.imem_req), 32'd1); chk("run_pcw", 32'(bus.pc_write), 32'd1);
    chk("run_src", 32'(bus.pc_src), 32'd0); chk("run_sc", 32'(bus.stall_count), 32'd0); adv();
    drive(0, 1, 1, 0, 1, 1); chk("simul_vec", 32'(dut_vec()), 32'h000000D6); adv();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 1, 1);
      chk("haz_pcw", 32'(bus.pc_write), 32'd0); chk("haz_idf", 32'(bus.idex_flush), 32'd1); adv();
    end
    drive(0, 0, 0, 0, 1, 1);
    chk("jmp_src", 32'(bus.pc_src), 32'd1); chk("jmp_iff", 32'(bus.ifid_flush), 32'd1);
    chk("haz_sc", 32'(bus.stall_count), 32'd2); adv();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("mw_iff", 32'(bus.ifid_flush), 32'd1); chk("mw_pcw", 32'(bus.pc_write), 32'd0); adv();
    end
    drive(0, 0, 0, 0, 0, 1);
    chk("mw_exit_pcw", 32'(bus.pc_write), 32'd1); chk("mw_exit_ifw", 32'(bus.ifid_write), 32'd1);
    chk("mw_sc", 32'(bus.stall_count), 32'd5); adv();
    drive(0, 0, 0, 0, 0, 1); chk("run_again_vec", 32'(dut_vec()), 32'h00000098); adv();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0); chk("pre_timeout_halted", 32'(bus.halted), 32'd0); adv();
    end
    drive(0, 1, 0, 0, 0, 1);
    chk("to_halted", 32'(bus.halted), 32'd1); chk("to_err", 32'(bus.fetch_error), 32'd1);
    chk("sat_sc", 32'(bus.stall_count), 32'd7); chk("halt_vec", 32'(dut_vec()), 32'(V_HALT)); adv();
    drive(0, 0, 0, 0, 1, 1); chk("halt_stay", 32'(bus.halted), 32'd1); adv();
    drive(1, 0, 0, 0, 0, 1); chk("rst_unhalt", 32'(bus.halted), 32'd0); adv();
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_err", 32'(bus.fetch_error), 32'd0); chk("rst_sc", 32'(bus.stall_count), 32'd0); adv();
    drive(0, 0, 0, 0, 0, 1); adv();
    drive(0, 0, 0, 0, 0, 0); adv();
    drive(0, 0, 0, 0, 0, 0); chk("mw_sc_pre", 32'(bus.stall_count), 32'd1); adv();
    drive(1, 0, 0, 0, 0, 0); chk("mid_rst_vec", 32'(dut_vec()), 32'(V_HOLD)); adv();
    drive(0, 0, 0, 0, 0, 1);
    chk("mid_rst_hold", 32'(dut_vec()), 32'(V_HOLD)); chk("mid_rst_sc", 32'(bus.stall_count), 32'd0); adv();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < (((i / 150) % 2 == 1) ? 25 : 80));
      adv();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Control unit that sequences the instruction-fetch datapath: PC register, 3:1 PC-source mux, instruction memory and IF/ID pipeline register.
- Each cycle it decides the next-PC source and whether the PC and IF/ID register load, flush or hold, arbitrating between branch redirect, load-use stall, jump, memory wait and halt.
- Adds a post-reset hold window, a memory-wait timeout and a saturating stall counter.

Parameters:
- RESET_HOLD_CYCLES, 2, cycles spent in HOLD after reset before the first fetch (>=1).
- MEM_TIMEOUT, 16, consecutive MEM_WAIT cycles that raise fetch_error (>=2).
- STALL_CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- branch_taken  in  1  EX-stage branch resolved taken; target is on the branch-address path.
- jump_req  in  1  ID-stage jump decoded; target is on the jump-address path.
- load_use_hazard  in  1  ID instruction depends on the load currently in EX.
- halt_req  in  1  ID-stage halt instruction decoded.
- imem_ready  in  1  instruction memory data for the current PC is valid this cycle.
- imem_req  out  1  fetch request for the current PC.
- pc_src  out  2  mux select: 00 = PC+4, 01 = jump, 10 = branch; 11 is never driven.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  load a zero instruction (bubble) into IF/ID.
- idex_flush  out  1  turn the ID/EX entry into a bubble.
- halted  out  1  controller is in HALTED.
- fetch_error  out  1  sticky flag: memory timeout occurred.
- stall_count  out  STALL_CNT_W  saturating count of stalled fetch cycles.

Behaviour:
- States: HOLD, RUN, MEM_WAIT, HALTED.
- Control outputs are combinational from state and inputs. stall_count, fetch_error and the wait counter are registered.
- Reset: any posedge with rst=1 sets state=HOLD, hold_cnt=0, wait_cnt=0, stall_count=0, fetch_error=0.
- While rst=1, outputs are forced to their HOLD values. This also applies when rst asserts mid-operation; any in-flight redirect is discarded.
- HOLD outputs: imem_req=0, pc_src=00, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, halted=0.
- HOLD timing: hold_cnt increments each cycle. After exactly RESET_HOLD_CYCLES HOLD cycles, the next state is RUN. With rst released before edge 0, the first RUN cycle follows RESET_HOLD_CYCLES edges later.
- RUN / MEM_WAIT: imem_req=1. Defaults are pc_src=00 and all enables/flushes 0. Conditions are evaluated in strict priority order:
  1. branch_taken: pc_src=10, pc_write=1, ifid_flush=1, idex_flush=1. Next state RUN. Overrides all lower conditions, including imem_ready=0.
  2. load_use_hazard: pc_write=0, ifid_write=0, idex_flush=1. Next state unchanged. A jump_req in the same cycle is ignored; it re-presents next cycle.
  3. halt_req: pc_write=0, ifid_flush=1. Next state HALTED.
  4. jump_req: pc_src=01, pc_write=1, ifid_flush=1. Next state RUN, regardless of imem_ready.
  5. imem_ready=0: pc_write=0, ifid_write=0, ifid_flush=1. Next state MEM_WAIT.
  6. Otherwise: pc_src=00, pc_write=1, ifid_write=1. Next state RUN.
- wait_cnt:
  - Increments on every cycle that ends in MEM_WAIT.
  - Clears on any exit from MEM_WAIT.
  - When wait_cnt reaches MEM_TIMEOUT while still waiting, next state is HALTED and fetch_error is set (sticky until rst).
- HALTED:
  - imem_req=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=0, halted=1.
  - All request inputs are ignored; only rst exits.
- stall_count:
  - Increments on each RUN/MEM_WAIT cycle with pc_write=0, including the halt_req cycle.
  - Saturates at all-ones, with no wrap.
  - Never counts in HOLD or HALTED.
- Invariants:
  - ifid_write and ifid_flush are never both 1.
  - pc_write=1 implies imem_req=1.

Decomposition:
- Shared package:
  - pc_src encodings PCSRC_SEQ=2'b00, PCSRC_JUMP=2'b01, PCSRC_BRANCH=2'b10.
  - State enum fetch_state_t {HOLD, RUN, MEM_WAIT, HALTED}.
- One natural sub-module, sat_counter (parameterised width, enable, sync clear), used for stall_count.
- Hold and wait counters stay inline.

Test Plan:
- Reset, RESET_HOLD_CYCLES=2: rst=1 for 3 cycles, then 0 -> 2 cycles of HOLD values (ifid_flush=1, imem_req=0), then imem_req=1, pc_write=1, pc_src=00; stall_count=0.
- Simultaneous events: RUN, imem_ready=1, branch_taken=1 together with load_use_hazard=1 and jump_req=1 -> pc_src=10, pc_write=1, ifid_flush=1, idex_flush=1; stall_count unchanged.
- Held hazard: load_use_hazard=1 for 2 cycles with jump_req=1 -> pc_write=0, idex_flush=1, stall_count +2. Then hazard drops -> pc_src=01, ifid_flush=1.
- Memory wait and recovery: imem_ready=0 for 3 cycles, then 1 -> MEM_WAIT, ifid_flush=1 for 3 cycles, stall_count=3, then pc_write=1, ifid_write=1, back in RUN.
- Timeout, MEM_TIMEOUT=4: imem_ready held 0 -> after the 4th MEM_WAIT cycle halted=1 and fetch_error=1. branch_taken=1 afterwards has no effect. rst clears both flags.
- Saturation and mid-op reset, STALL_CNT_W=3: 9 stall cycles -> stall_count stays 7. rst pulse during MEM_WAIT -> HOLD next cycle with stall_count=0.
